sbqm_teller_dispatch: RTL and testbench
=======================================

Name: sbqm_teller_dispatch

Overview:
- Sequences customers from the single-bank queue to T teller windows.
- Consumes the queue-manager status (empty, Pcout) and the end-photocell count pulse.
- Picks the next free teller round-robin, lights that teller's call lamp, and waits for the customer to leave the queue.
- Tracks each teller as IDLE/SERVING and times out no-show calls.

Parameters:
N, 3, queue-count width (matches queue manager Pcout width)
T, 3, number of teller windows (2..8)
TO_W, 8, call-timeout counter width
CALL_TIMEOUT, 200, cycles a call waits for a customer before it is abandoned (1..2^TO_W-1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
empty  in  1  queue empty flag from queue manager
Pcout  in  N  current queue occupancy
pass_end  in  1  one-cycle pulse: a customer crossed the end photocell
teller_req  in  T  level per teller: window open and ready for a customer
teller_done  in  T  one-cycle pulse per teller: service finished
call  out  T  one-hot call lamp (all zero when no call is active)
call_id  out  $clog2(T)  index of the teller being called; valid while call != 0
serving  out  T  per-teller SERVING flag
timeout  out  1  one-cycle pulse: the active call expired without a customer
busy_cnt  out  $clog2(T+1)  number of tellers in SERVING

Behaviour:
- Reset (async, reset_n=0): FSM=S_IDLE, call=0, call_id=0, serving=0, timeout=0, busy_cnt=0, rr_ptr=0, timer=0.
- Release of reset is taken synchronously on the next clk edge.
- All outputs are registered.
- Eligible set: E = teller_req & ~serving.
- S_IDLE, when !empty && E!=0:
  - pick the first set bit of E, searching circularly from rr_ptr.
  - call <= onehot(pick), call_id <= pick, timer <= 0, go to S_CALL.
  - Latency: call asserts on the edge after the condition is sampled.
- S_CALL, priority order within a cycle:
  - (1) pass_end=1: serving[call_id] <= 1, call <= 0, rr_ptr <= (call_id+1) mod T, go to S_IDLE.
  - (2) teller_req[call_id]=0: abort. call <= 0, rr_ptr unchanged, no timeout pulse, go to S_IDLE.
  - (3) timer == CALL_TIMEOUT-1: timeout <= 1 for one cycle, call <= 0, rr_ptr <= (call_id+1) mod T, go to S_IDLE.
  - (4) otherwise: timer <= timer+1.
- pass_end in S_IDLE is ignored (no state change).
- teller_done[t] with serving[t]=1 clears serving[t] the next cycle. With serving[t]=0 it is ignored.
- Multiple teller_done bits may clear in the same cycle.
- teller_done[call_id] and pass_end in the same cycle:
  - the clear applies to the prior service and the set applies to the new one; set wins.
  - serving[call_id] ends at 1.
- busy_cnt = popcount(serving), registered together with serving.
- empty rising during S_CALL does not abort the call; only the rules above end it.
- At most one call is active at any time.
- After returning to S_IDLE, a new call may start on the next edge.

Optional Feature:
SBQM_SERVED_STATS_EN
- Defined:
  - adds output served_total [15:0], incremented on every pass_end accepted in S_CALL; saturates at 16'hFFFF.
  - adds output noshow_total [7:0], incremented on every timeout; saturates at 8'hFF.
  - Both counters reset to 0 on reset_n.
- Undefined: neither port nor its counter logic exists. All other behaviour is identical.

Test Plan:
- Reset mid-call: T=3, empty=0, teller_req=3'b111, reset pulsed low while call=3'b001 -> call=0, serving=0, rr_ptr=0 immediately and asynchronously; the first call after release is 3'b001.
- Round-robin order: teller_req=3'b111, empty=0, pass_end one cycle after each call, teller_done immediately after each service -> calls in order 001, 010, 100, 001; busy_cnt never exceeds 1.
- Timeout: CALL_TIMEOUT=5, no pass_end -> timeout pulses exactly 5 cycles after call asserts; call=0 the same edge; the next call goes to the following teller.
- Abort: teller_req[1] drops while call=3'b010 -> call=0 next edge, no timeout pulse, serving unchanged; the next call re-searches from teller 1.
- Saturation of tellers: tellers 0 and 1 serving, teller_req=3'b011, empty=0 -> no call asserted; teller_done[0] pulse -> serving=3'b010, call=3'b001 one cycle later.
- Simultaneous events: pass_end at the same edge timer reaches CALL_TIMEOUT-1 -> serving set, timeout stays 0.
  - With SBQM_SERVED_STATS_EN defined: served_total +1, noshow_total unchanged.

Source files
------------

// File: rtl/sbqm_teller_dispatch.sv
// sbqm_teller_dispatch: hands customers from the single bank queue to T teller
// windows. A free, ready teller is picked round-robin, its call lamp is lit and
// the call holds until the customer crosses the end photocell, the teller closes
// the window, or the call times out. Each teller is tracked as IDLE/SERVING.
//
// Optional build macro: SBQM_SERVED_STATS_EN adds the served_total and
// noshow_total saturating counters together with their output ports.
module sbqm_teller_dispatch #(
   parameter int unsigned N            = 3,
   parameter int unsigned T            = 3,
   parameter int unsigned TO_W         = 8,
   parameter int unsigned CALL_TIMEOUT = 200
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     empty,
   input  logic [N-1:0]             Pcout,
   input  logic                     pass_end,
   input  logic [T-1:0]             teller_req,
   input  logic [T-1:0]             teller_done,
   output logic [T-1:0]             call,
   output logic [$clog2(T)-1:0]     call_id,
   output logic [T-1:0]             serving,
   output logic                     timeout,
   output logic [$clog2(T+1)-1:0]   busy_cnt
`ifdef SBQM_SERVED_STATS_EN
   ,
   output logic [15:0]              served_total,
   output logic [7:0]               noshow_total
`endif
);

   localparam int unsigned CW = $clog2(T);
   localparam int unsigned BW = $clog2(T + 1);
   localparam logic [T-1:0] CallLsb = {{(T - 1){1'b0}}, 1'b1};
   localparam logic [TO_W-1:0] TimerLast = TO_W'(CALL_TIMEOUT - 1);

   typedef enum logic [0:0] {StIdle, StCall} state_e;

   state_e         state_q;
   logic [CW-1:0]  rr_ptr_q;
   logic [TO_W-1:0] timer_q;

   logic [T-1:0]   elig;
   logic           pick_valid;
   logic [CW-1:0]  pick;
   logic [CW-1:0]  next_ptr;
   logic [T-1:0]   serving_d;
   logic [BW-1:0]  busy_d;

   // Occupancy is informational only; the empty flag alone gates a new call.
   logic unused_pcout;
   assign unused_pcout = ^Pcout;

   // Circular first-set search of the eligible tellers, starting at rr_ptr.
   always_comb begin
      int unsigned idx;
      idx        = 0;
      elig       = teller_req & ~serving;
      pick_valid = 1'b0;
      pick       = '0;
      for (int unsigned k = 0; k < T; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= T) begin
            idx = idx - T;
         end
         if (!pick_valid && elig[CW'(idx)]) begin
            pick_valid = 1'b1;
            pick       = CW'(idx);
         end
      end
   end

   // Pointer advances past the teller whose call just ended (served or no-show).
   always_comb begin
      next_ptr = (call_id == CW'(T - 1)) ? '0 : call_id + 1'b1;
   end

   // Service flags: done pulses clear first, an accepted pass_end sets last so
   // a simultaneous done+pass_end on the called teller leaves it SERVING.
   always_comb begin
      serving_d = serving & ~teller_done;
      if (state_q == StCall && pass_end) begin
         serving_d[call_id] = 1'b1;
      end
      busy_d = '0;
      for (int unsigned i = 0; i < T; i++) begin
         busy_d = busy_d + BW'(serving_d[i]);
      end
   end

   // Dispatch FSM with all outputs held in flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         timer_q      <= '0;
         call         <= '0;
         call_id      <= '0;
         serving      <= '0;
         timeout      <= 1'b0;
         busy_cnt     <= '0;
`ifdef SBQM_SERVED_STATS_EN
         served_total <= '0;
         noshow_total <= '0;
`endif
      end else begin
         timeout  <= 1'b0;
         serving  <= serving_d;
         busy_cnt <= busy_d;
         case (state_q)
            StIdle: begin
               if (!empty && pick_valid) begin
                  call    <= CallLsb << pick;
                  call_id <= pick;
                  timer_q <= '0;
                  state_q <= StCall;
               end
            end
            StCall: begin
               if (pass_end) begin
                  call     <= '0;
                  rr_ptr_q <= next_ptr;
                  state_q  <= StIdle;
`ifdef SBQM_SERVED_STATS_EN
                  if (served_total != 16'hFFFF) begin
                     served_total <= served_total + 16'd1;
                  end
`endif
               end else if (!teller_req[call_id]) begin
                  // Window closed while being called: drop quietly, same start point.
                  call    <= '0;
                  state_q <= StIdle;
               end else if (timer_q == TimerLast) begin
                  timeout  <= 1'b1;
                  call     <= '0;
                  rr_ptr_q <= next_ptr;
                  state_q  <= StIdle;
`ifdef SBQM_SERVED_STATS_EN
                  if (noshow_total != 8'hFF) begin
                     noshow_total <= noshow_total + 8'd1;
                  end
`endif
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: begin
               call    <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sbqm_teller_dispatch.sv
// Bench for sbqm_teller_dispatch (T=3, CALL_TIMEOUT=5): a directed vector table
// from reset, a mid-call asynchronous reset sequence, then random traffic
// checked against a behavioural model of the dispatch rules.
module tb_sbqm_teller_dispatch;

   localparam int unsigned N  = 3;
   localparam int unsigned T  = 3;
   localparam int unsigned TO = 5;

   logic       clk;
   logic       reset_n;
   logic       empty;
   logic [N-1:0] Pcout;
   logic       pass_end;
   logic [2:0] teller_req;
   logic [2:0] teller_done;
   logic [2:0] call;
   logic [1:0] call_id;
   logic [2:0] serving;
   logic       timeout;
   logic [1:0] busy_cnt;
`ifdef SBQM_SERVED_STATS_EN
   logic [15:0] served_total;
   logic [7:0]  noshow_total;
`endif

   sbqm_teller_dispatch #(
      .N            (N),
      .T            (T),
      .TO_W         (8),
      .CALL_TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .empty        (empty),
      .Pcout        (Pcout),
      .pass_end     (pass_end),
      .teller_req   (teller_req),
      .teller_done  (teller_done),
      .call         (call),
      .call_id      (call_id),
      .serving      (serving),
      .timeout      (timeout),
      .busy_cnt     (busy_cnt)
`ifdef SBQM_SERVED_STATS_EN
      ,
      .served_total (served_total),
      .noshow_total (noshow_total)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Directed vectors: inputs applied before an edge, outputs expected after it.
   typedef struct {
      logic       emp;
      logic       pe;
      logic [2:0] req;
      logic [2:0] done;
      logic [2:0] e_call;
      logic [2:0] e_srv;
      logic [1:0] e_busy;
      logic       e_to;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic e, input logic p, input logic [2:0] r, input logic [2:0] d,
                      input logic [2:0] c, input logic [2:0] s, input logic [1:0] b,
                      input logic t);
      vec_t v;
      v.emp = e; v.pe = p; v.req = r; v.done = d;
      v.e_call = c; v.e_srv = s; v.e_busy = b; v.e_to = t;
      vq.push_back(v);
   endtask

   task automatic drive(input logic e, input logic p, input logic [2:0] r, input logic [2:0] d);
      empty       = e;
      Pcout       = e ? 3'd0 : 3'd2;
      pass_end    = p;
      teller_req  = r;
      teller_done = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference: a call is either open (to teller m_id, waited
   // m_wait cycles) or not; tellers are a set of SERVING flags.
   bit       m_act;
   int       m_id;
   int       m_wait;
   bit [2:0] m_srv;
   int       m_rr;
   bit       m_to;
   int       m_served;
   int       m_noshow;

   task automatic model_reset();
      m_act = 0; m_id = 0; m_wait = 0; m_srv = '0; m_rr = 0; m_to = 0;
      m_served = 0; m_noshow = 0;
   endtask

   task automatic model_step(input bit e, input bit p, input bit [2:0] r, input bit [2:0] d);
      bit [2:0] free_ready;
      bit [2:0] srv_next;
      bit       found;
      free_ready = r & ~m_srv;
      srv_next   = m_srv & ~d;
      m_to       = 0;
      found      = 0;
      if (!m_act) begin
         if (!e) begin
            for (int k = 0; k < int'(T); k++) begin
               int t;
               t = (m_rr + k) % int'(T);
               if (!found && free_ready[t]) begin
                  found = 1;
                  m_id  = t;
               end
            end
            if (found) begin
               m_act  = 1;
               m_wait = 0;
            end
         end
      end else if (p) begin
         srv_next[m_id] = 1'b1;
         m_act = 0;
         m_rr  = (m_id + 1) % int'(T);
         if (m_served < 65535) m_served++;
      end else if (!r[m_id]) begin
         m_act = 0;
      end else if (m_wait == int'(TO) - 1) begin
         m_to  = 1;
         m_act = 0;
         m_rr  = (m_id + 1) % int'(T);
         if (m_noshow < 255) m_noshow++;
      end else begin
         m_wait++;
      end
      m_srv = srv_next;
   endtask

   task automatic check_model(input int cyc);
      logic [2:0] ec;
      bit ok;
      ec = m_act ? (3'b001 << m_id) : 3'b000;
      ok = (call === ec) && (serving === m_srv) && (timeout === m_to) &&
           (busy_cnt === 2'($countones(m_srv))) && (!m_act || call_id === 2'(m_id));
`ifdef SBQM_SERVED_STATS_EN
      ok = ok && (served_total === 16'(m_served)) && (noshow_total === 8'(m_noshow));
`endif
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rand cyc%0d: got call=%b id=%0d srv=%b busy=%0d to=%b, expected call=%b id=%0d srv=%b busy=%0d to=%b",
                  cyc, call, call_id, serving, busy_cnt, timeout,
                  ec, m_id, m_srv, $countones(m_srv), m_to);
      end
   endtask

   initial begin
      logic [1:0] eid;
      bit e, p;
      bit [2:0] r, d;

      reset_n = 1'b0;
      drive(1'b1, 1'b0, 3'b000, 3'b000);
      repeat (2) @(posedge clk);
      #1;
      chk("reset call", 32'(call), 32'd0);
      chk("reset call_id", 32'(call_id), 32'd0);
      chk("reset serving", 32'(serving), 32'd0);
      chk("reset timeout", 32'(timeout), 32'd0);
      chk("reset busy_cnt", 32'(busy_cnt), 32'd0);
`ifdef SBQM_SERVED_STATS_EN
      chk("reset served_total", 32'(served_total), 32'd0);
      chk("reset noshow_total", 32'(noshow_total), 32'd0);
`endif
      reset_n = 1'b1;

      // Round-robin with immediate release, idle pass_end ignored.
      add(0, 0, 3'b111, 3'b000, 3'b001, 3'b000, 2'd0, 0);
      add(0, 1, 3'b111, 3'b000, 3'b000, 3'b001, 2'd1, 0);
      add(0, 0, 3'b111, 3'b001, 3'b010, 3'b000, 2'd0, 0);
      add(0, 1, 3'b111, 3'b000, 3'b000, 3'b010, 2'd1, 0);
      add(0, 0, 3'b111, 3'b010, 3'b100, 3'b000, 2'd0, 0);
      add(0, 1, 3'b111, 3'b000, 3'b000, 3'b100, 2'd1, 0);
      add(0, 0, 3'b111, 3'b100, 3'b001, 3'b000, 2'd0, 0);
      add(0, 1, 3'b111, 3'b000, 3'b000, 3'b001, 2'd1, 0);
      add(1, 0, 3'b111, 3'b001, 3'b000, 3'b000, 2'd0, 0);
      add(1, 1, 3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 0);
      // Abort on teller 1, re-search from teller 1, then a no-show timeout.
      add(0, 0, 3'b111, 3'b000, 3'b010, 3'b000, 2'd0, 0);
      add(0, 0, 3'b101, 3'b000, 3'b000, 3'b000, 2'd0, 0);
      add(0, 0, 3'b111, 3'b000, 3'b010, 3'b000, 2'd0, 0);
      repeat (4) add(0, 0, 3'b111, 3'b000, 3'b010, 3'b000, 2'd0, 0);
      add(0, 0, 3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 1);
      add(0, 0, 3'b111, 3'b000, 3'b100, 3'b000, 2'd0, 0);
      // Fill tellers until none eligible, then free one.
      add(0, 1, 3'b111, 3'b000, 3'b000, 3'b100, 2'd1, 0);
      add(0, 0, 3'b011, 3'b000, 3'b001, 3'b100, 2'd1, 0);
      add(0, 1, 3'b011, 3'b000, 3'b000, 3'b101, 2'd2, 0);
      add(0, 0, 3'b011, 3'b100, 3'b010, 3'b001, 2'd1, 0);
      add(0, 1, 3'b011, 3'b000, 3'b000, 3'b011, 2'd2, 0);
      add(0, 0, 3'b011, 3'b000, 3'b000, 3'b011, 2'd2, 0);
      add(0, 0, 3'b011, 3'b000, 3'b000, 3'b011, 2'd2, 0);
      add(0, 0, 3'b011, 3'b001, 3'b000, 3'b010, 2'd1, 0);
      add(0, 0, 3'b011, 3'b000, 3'b001, 3'b010, 2'd1, 0);
      // done and pass_end on the called teller together: set wins.
      add(0, 1, 3'b011, 3'b001, 3'b000, 3'b011, 2'd2, 0);
      add(0, 0, 3'b011, 3'b010, 3'b000, 3'b001, 2'd1, 0);
      // pass_end on the final timer cycle: served, not timed out.
      add(0, 0, 3'b111, 3'b000, 3'b010, 3'b001, 2'd1, 0);
      repeat (4) add(0, 0, 3'b111, 3'b000, 3'b010, 3'b001, 2'd1, 0);
      add(0, 1, 3'b111, 3'b000, 3'b000, 3'b011, 2'd2, 0);
      // Two done pulses at once.
      add(1, 0, 3'b111, 3'b011, 3'b000, 3'b000, 2'd0, 0);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].emp, vq[i].pe, vq[i].req, vq[i].done);
         tick();
         chk($sformatf("row%0d call", i), 32'(call), 32'(vq[i].e_call));
         chk($sformatf("row%0d serving", i), 32'(serving), 32'(vq[i].e_srv));
         chk($sformatf("row%0d busy_cnt", i), 32'(busy_cnt), 32'(vq[i].e_busy));
         chk($sformatf("row%0d timeout", i), 32'(timeout), 32'(vq[i].e_to));
         if (vq[i].e_call != 3'b000) begin
            eid = 2'd0;
            if (vq[i].e_call == 3'b010) eid = 2'd1;
            if (vq[i].e_call == 3'b100) eid = 2'd2;
            chk($sformatf("row%0d call_id", i), 32'(call_id), 32'(eid));
         end
      end
`ifdef SBQM_SERVED_STATS_EN
      chk("table served_total", 32'(served_total), 32'd9);
      chk("table noshow_total", 32'(noshow_total), 32'd1);
`endif

      // Reset mid-call: call=001 with teller 2 serving, then async reset.
      drive(0, 0, 3'b111, 3'b000);
      tick();
      chk("rst seq call 100", 32'(call), 32'b100);
      drive(0, 1, 3'b111, 3'b000);
      tick();
      drive(0, 0, 3'b111, 3'b000);
      tick();
      chk("rst seq call 001", 32'(call), 32'b001);
      chk("rst seq serving", 32'(serving), 32'b100);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async rst call", 32'(call), 32'd0);
      chk("async rst serving", 32'(serving), 32'd0);
      chk("async rst busy_cnt", 32'(busy_cnt), 32'd0);
      tick();
      chk("held rst call", 32'(call), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("first call after rst", 32'(call), 32'b001);
      chk("first call_id after rst", 32'(call_id), 32'd0);

      // Random traffic against the model from a clean reset.
      reset_n = 1'b0;
      drive(1, 0, 3'b000, 3'b000);
      tick();
      reset_n = 1'b1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         e = ($urandom_range(0, 3) == 0);
         p = ($urandom_range(0, 3) == 0);
         for (int b = 0; b < 3; b++) begin
            r[b] = ($urandom_range(0, 15) != 0);
            d[b] = ($urandom_range(0, 5) == 0);
         end
         drive(e, p, r, d);
         model_step(e, p, r, d);
         tick();
         check_model(c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
